// File: rtl/pc_sequencer_if.sv
// Pipeline <-> PC sequencer bundle: fetch control inputs and PC steering outputs.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0]  pc_cur;
  logic             icache_stall;
  logic             dcache_stall;
  logic             hazard_stall;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;

  logic             pc_load;
  logic [XLEN-1:0]  pc_next;
  logic             flush_if_id;
  logic             fetch_valid;
  logic             trap;
  logic [XLEN-1:0]  trap_epc;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies PC/stall/redirect, consumes steering.
  modport master (
    output pc_cur, icache_stall, dcache_stall, hazard_stall,
           redirect_valid, redirect_target,
    input  pc_load, pc_next, flush_if_id, fetch_valid, trap, trap_epc, stall_cnt
  );

  // Sequencer side.
  modport slave (
    input  pc_cur, icache_stall, dcache_stall, hazard_stall,
           redirect_valid, redirect_target,
    output pc_load, pc_next, flush_if_id, fetch_valid, trap, trap_epc, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: chooses next PC (sequential / redirect / deferred redirect),
// freezes on stalls, counts non-load cycles.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned load target traps
// to TRAP_VECTOR; otherwise redirect targets are forced word-aligned).
// Reset is synchronous, active-low.
module pc_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
  parameter int unsigned CNT_W       = 16
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD       = 2'd2,
    REDIR_PEND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pend_target_q, pend_target_d;
  logic [XLEN-1:0]  trap_epc_q, trap_epc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             stall_c;
  logic             is_redir_c;
  logic [XLEN-1:0]  chosen_c;
  logic             pc_load_c;
  logic [XLEN-1:0]  pc_next_c;
  logic             flush_c;
  logic             fetch_c;
  logic             trap_c;

  assign stall_c = bus.icache_stall | bus.dcache_stall | bus.hazard_stall;

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  // Next-state and steering decode; redirect beats increment, stall blocks load.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    trap_epc_d    = trap_epc_q;
    stall_cnt_d   = stall_cnt_q;
    is_redir_c    = 1'b0;
    chosen_c      = '0;
    pc_load_c     = 1'b0;
    pc_next_c     = '0;
    flush_c       = 1'b0;
    fetch_c       = 1'b0;
    trap_c        = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (!stall_c) begin
          pc_load_c = 1'b1;
          state_d   = RUN;
          if (bus.redirect_valid) begin
            is_redir_c = 1'b1;
            chosen_c   = bus.redirect_target;
          end else begin
            chosen_c   = bus.pc_cur + XLEN'(4);
          end
        end else if (bus.redirect_valid) begin
          pend_target_d = bus.redirect_target;
          state_d       = REDIR_PEND;
        end else begin
          state_d = HOLD;
        end
      end
      REDIR_PEND: begin
        if (stall_c) begin
          if (bus.redirect_valid) pend_target_d = bus.redirect_target;
        end else begin
          pc_load_c  = 1'b1;
          is_redir_c = 1'b1;
          chosen_c   = bus.redirect_valid ? bus.redirect_target : pend_target_q;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (pc_load_c) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (chosen_c[1:0] != 2'b00) begin
        pc_next_c  = TRAP_VECTOR;
        trap_c     = 1'b1;
        flush_c    = 1'b1;
        trap_epc_d = chosen_c;
      end else begin
        pc_next_c = chosen_c;
        flush_c   = is_redir_c;
        fetch_c   = ~is_redir_c;
      end
`else
      pc_next_c = is_redir_c ? {chosen_c[XLEN-1:2], 2'b00} : chosen_c;
      flush_c   = is_redir_c;
      fetch_c   = ~is_redir_c;
`endif
    end

    if (!pc_load_c && (state_q != BOOT) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (!rst_n) begin
      pc_load_c = 1'b0;
      pc_next_c = '0;
      flush_c   = 1'b0;
      fetch_c   = 1'b0;
      trap_c    = 1'b0;
    end
  end

  // State and bookkeeping registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pend_target_q <= '0;
      trap_epc_q    <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      trap_epc_q    <= trap_epc_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.pc_load     = pc_load_c;
  assign bus.pc_next     = pc_next_c;
  assign bus.flush_if_id = flush_c;
  assign bus.fetch_valid = fetch_c;
  assign bus.trap        = trap_c;
  assign bus.trap_epc    = trap_epc_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model predictions per cycle,
// negedge monitor pops and compares. Honours PC_MISALIGN_TRAP_EN if defined.
module tb_pc_sequencer;
  localparam int unsigned CW       = 4;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.CNT_W(CW)) bus ();

  pc_sequencer #(.TRAP_VECTOR(TRAP_VEC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          load;
    logic [31:0]   next;
    logic          flush;
    logic          fetch;
    logic          trap;
    logic [31:0]   epc;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: PC register, pending-redirect flag/value, boot flag, counters.
  logic [31:0]   pc_reg    = 32'h0;
  logic          m_boot    = 1'b1;
  logic          m_pending = 1'b0;
  logic [31:0]   m_pend    = 32'h0;
  logic [31:0]   m_epc     = 32'h0;
  logic [CW-1:0] m_cnt     = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents its steering outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_load",     32'(bus.pc_load),     32'(e.load));
      chk("pc_next",     bus.pc_next,          e.next);
      chk("flush_if_id", 32'(bus.flush_if_id), 32'(e.flush));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(e.fetch));
      chk("trap",        32'(bus.trap),        32'(e.trap));
      chk("trap_epc",    bus.trap_epc,         e.epc);
      chk("stall_cnt",   32'(bus.stall_cnt),   32'(e.cnt));
    end
  end

  task automatic cycle(input logic rst, input logic ic, input logic dc, input logic hz,
                       input logic rv, input logic [31:0] rt);
    exp_t        e;
    logic [31:0] tgt;
    logic        isr;
    @(posedge clk);
    #1;
    rst_n               = rst;
    bus.pc_cur          = pc_reg;
    bus.icache_stall    = ic;
    bus.dcache_stall    = dc;
    bus.hazard_stall    = hz;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    e.load = 1'b0; e.next = 32'h0; e.flush = 1'b0; e.fetch = 1'b0; e.trap = 1'b0;
    e.epc = m_epc; e.cnt = m_cnt;
    if (!rst) begin
      m_boot = 1'b1; m_pending = 1'b0; m_pend = 32'h0; m_epc = 32'h0; m_cnt = '0;
      pc_reg = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!(ic | dc | hz)) begin
      isr = rv | m_pending;
      tgt = rv ? rt : (m_pending ? m_pend : pc_reg + 32'd4);
      m_pending = 1'b0;
      e.load = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        e.next = TRAP_VEC; e.trap = 1'b1; e.flush = 1'b1; m_epc = tgt;
      end else begin
        e.next = tgt; e.flush = isr; e.fetch = !isr;
      end
`else
      e.next  = isr ? (tgt & 32'hFFFF_FFFC) : tgt;
      e.flush = isr;
      e.fetch = !isr;
`endif
      pc_reg = e.next;
    end else begin
      if (rv) begin m_pending = 1'b1; m_pend = rt; end
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
    end
    q.push_back(e);
  endtask

  task automatic run(input logic [31:0] rt);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rt);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pc_cur = '0; bus.icache_stall = 1'b0; bus.dcache_stall = 1'b0;
    bus.hazard_stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    repeat (2) @(posedge clk);

    // Reset state, then BOOT and sequential 0x4, 0x8, 0xC.
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) run(32'h0);

    // Unstalled redirect from 0x100 to 0x200.
    pc_reg = 32'h100;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    run(32'h0);

    // Fresh counter: 3 stall cycles, redirects 0x300 then 0x400, then release.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run(32'h0);
    run(32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
    run(32'h0);
    run(32'h0);

    // PC wrap at top of address space.
    pc_reg = 32'hFFFF_FFFC;
    run(32'h0);
    run(32'h0);

    // Misaligned redirect target, then a cycle to observe trap_epc.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h202);
    run(32'h0);

    // Reset while a 0x500 redirect is pending: must never load.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h500);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) run(32'h0);

    // Long stall to reach counter saturation.
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    run(32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom();
      if ($urandom_range(0, 3) != 0) rt = rt & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), rt);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
